accum_controller: RTL and testbench

Sequencing controller for the 16-bit accumulator of the CPU datapath. Accepts one ALU command per valid/ready handshake, reads the current accumulator value, computes the result, and drives the accumulator's load or write-enable inputs. Sits between the instruction decoder and the accumulator; it is the only writer of the accumulator.

---
 rtl/accum_controller_if.sv | 29 ++
 rtl/accum_controller.sv | 179 +++++++++++++++++
 tb/tb_accum_controller.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/accum_controller_if.sv
// Command/accumulator bus for accum_controller: decoder handshake, accumulator
// read-back and write strobes, plus completion and status flags.
interface accum_controller_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_operand;
  logic [15:0] acc_in;
  logic        acc_load;
  logic [15:0] acc_load_data;
  logic        acc_valid;
  logic [15:0] acc_din;
  logic        done;
  logic        err;
  logic        flag_zero;
  logic        flag_carry;

  modport master (
    output cmd_valid, cmd_op, cmd_operand, acc_in,
    input  cmd_ready, acc_load, acc_load_data, acc_valid, acc_din,
           done, err, flag_zero, flag_carry
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_operand, acc_in,
    output cmd_ready, acc_load, acc_load_data, acc_valid, acc_din,
           done, err, flag_zero, flag_carry
  );
endinterface

// File: rtl/accum_controller.sv
// Sequencing controller for the 16-bit accumulator: one ALU command per handshake.
// Optional shift-add multiplier (opcode B) compiled in with ACCUM_CTRL_MUL_EN.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for handshake
// EXEC  | sample acc_in, compute result (or start multiply)
// MUL   | 16 shift-add iterations, one multiplier bit per cycle
// WRITE | strobes, done and err valid for exactly this cycle
module accum_controller (
  input  logic             clk,
  input  logic             reset_n,
  accum_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, WRITE} state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_CLR  = 4'hA;
`ifdef ACCUM_CTRL_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'hB;
`endif

  state_t      state;
  logic [3:0]  op_q;
  logic [15:0] operand_q;

  logic [16:0] sum;
  logic [15:0] res;
  logic        do_load;
  logic        do_write;
  logic        illegal;
  logic        upd_carry;
  logic        carry_new;
  logic        go_mul;

`ifdef ACCUM_CTRL_MUL_EN
  logic [31:0] mcand_q;
  logic [15:0] mplier_q;
  logic [31:0] prod_q;
  logic [3:0]  cnt_q;
  logic [31:0] prod_next;

  assign prod_next = prod_q + (mplier_q[0] ? mcand_q : 32'd0);
`endif

  assign sum = {1'b0, bus.acc_in} + {1'b0, operand_q};

  always_comb begin
    res       = '0;
    do_load   = 1'b0;
    do_write  = 1'b0;
    illegal   = 1'b0;
    upd_carry = 1'b0;
    carry_new = 1'b0;
    go_mul    = 1'b0;
    case (op_q)
      OP_NOP:  ;
      OP_LOAD: begin do_load = 1'b1; res = operand_q; end
      OP_ADD:  begin
        do_write = 1'b1; res = sum[15:0];
        upd_carry = 1'b1; carry_new = sum[16];
      end
      OP_SUB:  begin
        do_write = 1'b1; res = bus.acc_in - operand_q;
        upd_carry = 1'b1; carry_new = (bus.acc_in < operand_q);
      end
      OP_AND:  begin do_write = 1'b1; res = bus.acc_in & operand_q; end
      OP_OR:   begin do_write = 1'b1; res = bus.acc_in | operand_q; end
      OP_XOR:  begin do_write = 1'b1; res = bus.acc_in ^ operand_q; end
      OP_NOT:  begin do_write = 1'b1; res = ~bus.acc_in; end
      OP_SHL:  begin
        do_write = 1'b1; res = {bus.acc_in[14:0], 1'b0};
        upd_carry = 1'b1; carry_new = bus.acc_in[15];
      end
      OP_SHR:  begin
        do_write = 1'b1; res = {1'b0, bus.acc_in[15:1]};
        upd_carry = 1'b1; carry_new = bus.acc_in[0];
      end
      OP_CLR:  begin do_load = 1'b1; res = '0; end
`ifdef ACCUM_CTRL_MUL_EN
      OP_MUL:  go_mul = 1'b1;
`endif
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      op_q              <= '0;
      operand_q         <= '0;
      bus.cmd_ready     <= 1'b0;
      bus.acc_load      <= 1'b0;
      bus.acc_load_data <= '0;
      bus.acc_valid     <= 1'b0;
      bus.acc_din       <= '0;
      bus.done          <= 1'b0;
      bus.err           <= 1'b0;
      bus.flag_zero     <= 1'b0;
      bus.flag_carry    <= 1'b0;
`ifdef ACCUM_CTRL_MUL_EN
      mcand_q           <= '0;
      mplier_q          <= '0;
      prod_q            <= '0;
      cnt_q             <= '0;
`endif
    end else begin
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.acc_load  <= 1'b0;
      bus.acc_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_ready && bus.cmd_valid) begin
            bus.cmd_ready <= 1'b0;
            op_q          <= bus.cmd_op;
            operand_q     <= bus.cmd_operand;
            state         <= EXEC;
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end
        EXEC: begin
          if (go_mul) begin
`ifdef ACCUM_CTRL_MUL_EN
            mcand_q  <= {16'd0, bus.acc_in};
            mplier_q <= operand_q;
            prod_q   <= '0;
            cnt_q    <= 4'd15;
            state    <= MUL;
`endif
          end else begin
            state         <= WRITE;
            bus.done      <= 1'b1;
            bus.err       <= illegal;
            bus.acc_load  <= do_load;
            bus.acc_valid <= do_write;
            if (do_load)  bus.acc_load_data <= res;
            if (do_write) bus.acc_din       <= res;
            if (do_load || do_write) bus.flag_zero <= (res == 16'd0);
            if (upd_carry) bus.flag_carry <= carry_new;
          end
        end
`ifdef ACCUM_CTRL_MUL_EN
        MUL: begin
          prod_q   <= prod_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - 4'd1;
          // Terminal count: this edge folds in multiplier bit 15.
          if (cnt_q == 4'd0) begin
            state          <= WRITE;
            bus.done       <= 1'b1;
            bus.acc_valid  <= 1'b1;
            bus.acc_din    <= prod_next[15:0];
            bus.flag_zero  <= (prod_next[15:0] == 16'd0);
            bus.flag_carry <= |prod_next[31:16];
          end
        end
`endif
        WRITE: begin
          state         <= IDLE;
          bus.cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_controller.sv
// Directed, table-driven bench for accum_controller; follows ACCUM_CTRL_MUL_EN
// so expectations for opcode B match the build under test.
module tb_accum_controller;

`ifdef ACCUM_CTRL_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  accum_controller_if bus ();

  accum_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] operand;
    logic [15:0] acc;
    logic        load;
    logic        valid;
    logic [15:0] data;
    logic        err;
    logic        zero;
    logic        carry;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic [3:0] op, input logic [15:0] operand,
                              input logic [15:0] acc, input logic load, input logic valid,
                              input logic [15:0] data, input logic err, input logic zero,
                              input logic carry, input int lat);
    vec_t v;
    v.op = op; v.operand = operand; v.acc = acc; v.load = load; v.valid = valid;
    v.data = data; v.err = err; v.zero = zero; v.carry = carry; v.lat = lat;
    vecs.push_back(v);
  endfunction

  // Strobes must be exclusive and only appear alongside done.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("strobe_excl", {31'd0, bus.acc_load & bus.acc_valid}, 32'd0);
      chk("strobe_without_done", {31'd0, (bus.acc_load | bus.acc_valid) & ~bus.done}, 32'd0);
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.cmd_ready}, 32'd0);
    chk({tag, "_done"},  {31'd0, bus.done}, 32'd0);
    chk({tag, "_err"},   {31'd0, bus.err}, 32'd0);
    chk({tag, "_load"},  {31'd0, bus.acc_load}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.acc_valid}, 32'd0);
    chk({tag, "_ldata"}, {16'd0, bus.acc_load_data}, 32'd0);
    chk({tag, "_din"},   {16'd0, bus.acc_din}, 32'd0);
    chk({tag, "_zero"},  {31'd0, bus.flag_zero}, 32'd0);
    chk({tag, "_carry"}, {31'd0, bus.flag_carry}, 32'd0);
  endtask

  // Entered just after a negedge; drives at a negedge where cmd_ready is high.
  task automatic handshake(input logic [3:0] op, input logic [15:0] operand,
                           input logic [15:0] acc, input string tag);
    int n = 0;
    while (!bus.cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_wait"}, {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_operand = operand;
    bus.acc_in      = acc;
    @(posedge clk);
    #1;
    // Held request with a changed payload must be ignored while busy.
    bus.cmd_op      = 4'h1;
    bus.cmd_operand = 16'hDEAD;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat = 0;
    int ready_hi = 0;
    bit got = 0;
    handshake(v.op, v.operand, v.acc, tag);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (bus.cmd_ready) ready_hi++;
      if (bus.done) got = 1;
    end
    chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_ready_busy"}, ready_hi, 0);
    chk({tag, "_load"}, {31'd0, bus.acc_load}, {31'd0, v.load});
    chk({tag, "_valid"}, {31'd0, bus.acc_valid}, {31'd0, v.valid});
    if (v.load)  chk({tag, "_ldata"}, {16'd0, bus.acc_load_data}, {16'd0, v.data});
    if (v.valid) chk({tag, "_din"}, {16'd0, bus.acc_din}, {16'd0, v.data});
    chk({tag, "_err"}, {31'd0, bus.err}, {31'd0, v.err});
    chk({tag, "_zero"}, {31'd0, bus.flag_zero}, {31'd0, v.zero});
    chk({tag, "_carry"}, {31'd0, bus.flag_carry}, {31'd0, v.carry});
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_err_pulse"}, {31'd0, bus.err}, 32'd0);
    chk({tag, "_ready_after"}, {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    //  op     operand   acc      ld val data     err z  c  lat
    add(4'h1, 16'h1234, 16'h0000, 1, 0, 16'h1234, 0, 0, 0, 2);  // LOAD
    add(4'h2, 16'h0001, 16'hFFFF, 0, 1, 16'h0000, 0, 1, 1, 2);  // ADD wrap
    add(4'h3, 16'h0005, 16'h0003, 0, 1, 16'hFFFE, 0, 0, 1, 2);  // SUB borrow
    add(4'h4, 16'h00F0, 16'hFFFE, 0, 1, 16'h00F0, 0, 0, 1, 2);  // AND, carry holds
    add(4'h5, 16'h0F00, 16'h00F0, 0, 1, 16'h0FF0, 0, 0, 1, 2);  // OR
    add(4'h6, 16'h0FF0, 16'h0FF0, 0, 1, 16'h0000, 0, 1, 1, 2);  // XOR -> 0
    add(4'h7, 16'h1234, 16'h0000, 0, 1, 16'hFFFF, 0, 0, 1, 2);  // NOT
    add(4'h8, 16'h0000, 16'h8001, 0, 1, 16'h0002, 0, 0, 1, 2);  // SHL out 1
    add(4'h9, 16'h0000, 16'h0002, 0, 1, 16'h0001, 0, 0, 0, 2);  // SHR out 0
    add(4'h8, 16'h0000, 16'h4000, 0, 1, 16'h8000, 0, 0, 0, 2);  // SHL out 0
    add(4'hA, 16'hBEEF, 16'h5555, 1, 0, 16'h0000, 0, 1, 0, 2);  // CLR
    add(4'h0, 16'h7777, 16'h1111, 0, 0, 16'h0000, 0, 1, 0, 2);  // NOP holds
    add(4'hE, 16'h7777, 16'h1111, 0, 0, 16'h0000, 1, 1, 0, 2);  // illegal
    add(4'h2, 16'h8000, 16'h8000, 0, 1, 16'h0000, 0, 1, 1, 2);  // ADD carry, zero
    add(4'h3, 16'h0005, 16'h0005, 0, 1, 16'h0000, 0, 1, 0, 2);  // SUB equal
    if (MUL_EN) begin
      add(4'hB, 16'h0101, 16'h0100, 0, 1, 16'h0100, 0, 0, 1, 18);
      add(4'hB, 16'h0005, 16'h0003, 0, 1, 16'h000F, 0, 0, 0, 18);
      add(4'hF, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 2);
      add(4'hC, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 2);
    end else begin
      add(4'hB, 16'h0101, 16'h0100, 0, 0, 16'h0000, 1, 1, 0, 2);
      add(4'hB, 16'h0005, 16'h0003, 0, 0, 16'h0000, 1, 1, 0, 2);
      add(4'hF, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 2);
      add(4'hC, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 2);
    end

    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 4'h0;
    bus.cmd_operand = 16'h0000;
    bus.acc_in      = 16'h0000;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    #1;
    chk("release_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    chk("release_ready_high", {31'd0, bus.cmd_ready}, 32'd1);

    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], $sformatf("v%0d", i));

    // Abort an in-flight op with reset; nothing may be written.
    v.op = 4'h1; v.operand = 16'h5A5A; v.acc = 16'h0000; v.load = 1; v.valid = 0;
    v.data = 16'h5A5A; v.err = 0; v.zero = 0; v.carry = 0; v.lat = 2;
    run_vec(v, "pre_load");
    v.op = 4'h2; v.operand = 16'h0002; v.acc = 16'hFFFF; v.load = 0; v.valid = 1;
    v.data = 16'h0001; v.zero = 0; v.carry = 1;
    run_vec(v, "pre_add");
    handshake(MUL_EN ? 4'hB : 4'h2, 16'h0101, 16'h0100, "abort");
    repeat (MUL_EN ? 9 : 1) @(negedge clk);
    chk("abort_busy", {31'd0, bus.cmd_ready}, 32'd0);
    chk("abort_no_done_yet", {31'd0, bus.done}, 32'd0);
    reset_n = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clk);
    check_all_zero("abort_hold");
    reset_n = 1'b1;
    #1;
    chk("rerelease_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    chk("rerelease_ready_high", {31'd0, bus.cmd_ready}, 32'd1);
    v.op = 4'h1; v.operand = 16'h00AA; v.acc = 16'h0000; v.load = 1; v.valid = 0;
    v.data = 16'h00AA; v.err = 0; v.zero = 0; v.carry = 0; v.lat = 2;
    run_vec(v, "post_load");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
